// File: rtl/pe_param.sv
// Parametrised systolic processing element: two operand FIFOs, a four-stage
// multiply/accumulate pipeline with stall, rounding right-shift and saturation.

module pe_param_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] din_i,
    input  logic          we_i,
    input  logic          pop_i,
    output logic          full_o,
    output logic          empty_o,
    output logic [DW-1:0] dout_o,
    output logic          drop_o
);
    localparam int PW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   cnt_q, cnt_d;
    logic          push;

    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign push    = we_i & ~full_o;
    assign drop_o  = we_i & full_o;
    assign dout_o  = mem_q[rd_ptr_q];

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop_i})
            2'b10:   cnt_d = cnt_q + (PW+1)'(1);
            2'b01:   cnt_d = cnt_q - (PW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push)  wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_i) rd_ptr_q <= rd_ptr_q + PW'(1);
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset; the pointers define which words are live.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din_i;
    end
endmodule

module pe_param #(
    parameter int DW    = 16,
    parameter int AW    = 40,
    parameter int DEPTH = 4,
    parameter int CW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] a_in,
    input  logic          a_we,
    input  logic [DW-1:0] b_in,
    input  logic          b_we,
    output logic          a_full,
    output logic          b_full,
    input  logic          start,
    input  logic [CW-1:0] len,
    input  logic [5:0]    shamt,
    input  logic          stall,
    output logic [DW-1:0] a_out,
    output logic [DW-1:0] b_out,
    output logic          ab_valid,
    output logic          start_next,
    output logic [DW-1:0] s_out,
    output logic          s_valid,
    output logic          sat,
    output logic          ovf
);
    localparam logic signed [AW:0] SMAX = {{(AW-DW+2){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW:0] SMIN = {{(AW-DW+2){1'b1}}, {(DW-1){1'b0}}};

    logic                 a_empty, b_empty, a_drop, b_drop, fire;
    logic [DW-1:0]        a_dout, b_dout;

    logic                 s1_vld_q, s2_vld_q, pe_vld_q, s_vld_q;
    logic signed [DW-1:0] opa_q, opb_q;
    logic signed [2*DW-1:0] p_q;
    logic signed [AW-1:0] pe_q, acc_q;
    logic [CW-1:0]        cnt_q, len_r_q;
    logic [5:0]           shamt_r_q;
    logic [DW-1:0]        s_out_q;
    logic                 sat_q, ovf_q, start_next_q;

    logic signed [AW-1:0] sum_w;
    logic signed [AW:0]   sum_x, rnd_x, shf_x;
    logic [DW-1:0]        res_w;
    logic                 sat_w;

    assign fire = ~a_empty & ~b_empty & ~stall & ~start;

    pe_param_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .din_i   (a_in),
        .we_i    (a_we),
        .pop_i   (fire),
        .full_o  (a_full),
        .empty_o (a_empty),
        .dout_o  (a_dout),
        .drop_o  (a_drop)
    );

    pe_param_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .din_i   (b_in),
        .we_i    (b_we),
        .pop_i   (fire),
        .full_o  (b_full),
        .empty_o (b_empty),
        .dout_o  (b_dout),
        .drop_o  (b_drop)
    );

    // Operand, product and sign-extended product stages; start discards in-flight pairs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            pe_vld_q <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            p_q      <= '0;
            pe_q     <= '0;
        end else if (start) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            pe_vld_q <= 1'b0;
        end else if (!stall) begin
            s1_vld_q <= fire;
            s2_vld_q <= s1_vld_q;
            pe_vld_q <= s2_vld_q;
            if (fire) begin
                opa_q <= a_dout;
                opb_q <= b_dout;
            end
            if (s1_vld_q) p_q  <= (2*DW)'(opa_q) * (2*DW)'(opb_q);
            if (s2_vld_q) pe_q <= AW'(p_q);
        end
    end

    // Rounding is done one bit wider than the accumulator so the bias cannot wrap.
    always_comb begin
        sum_w = acc_q + pe_q;
        sum_x = {sum_w[AW-1], sum_w};
        rnd_x = '0;
        if (shamt_r_q != 6'd0) rnd_x = (AW+1)'(1) << (shamt_r_q - 6'd1);
        shf_x = (sum_x + rnd_x) >>> shamt_r_q;
        res_w = shf_x[DW-1:0];
        sat_w = 1'b0;
        if (shf_x > SMAX) begin
            res_w = SMAX[DW-1:0];
            sat_w = 1'b1;
        end else if (shf_x < SMIN) begin
            res_w = SMIN[DW-1:0];
            sat_w = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            len_r_q   <= '0;
            shamt_r_q <= '0;
            s_vld_q   <= 1'b0;
            s_out_q   <= '0;
            sat_q     <= 1'b0;
        end else if (start) begin
            acc_q     <= '0;
            cnt_q     <= len;
            len_r_q   <= len;
            shamt_r_q <= shamt;
            if (!stall) s_vld_q <= 1'b0;
        end else if (!stall) begin
            s_vld_q <= pe_vld_q && (cnt_q == '0);
            if (pe_vld_q) begin
                if (cnt_q != '0) begin
                    acc_q <= sum_w;
                    cnt_q <= cnt_q - CW'(1);
                end else begin
                    acc_q   <= '0;
                    cnt_q   <= len_r_q;
                    s_out_q <= res_w;
                    sat_q   <= sat_w;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q        <= 1'b0;
            start_next_q <= 1'b0;
        end else begin
            start_next_q <= start;
            if (start)                ovf_q <= 1'b0;
            else if (a_drop | b_drop) ovf_q <= 1'b1;
        end
    end

    // Strobes are held in their stage registers during stall and shown once afterwards.
    assign a_out      = opa_q;
    assign b_out      = opb_q;
    assign ab_valid   = s1_vld_q & ~stall;
    assign s_valid    = s_vld_q & ~stall;
    assign s_out      = s_out_q;
    assign sat        = sat_q & s_valid;
    assign ovf        = ovf_q;
    assign start_next = start_next_q;
endmodule

// File: tb/tb_pe_param.sv
// Self-checking bench for pe_param: expected results are queued as operands are
// driven and matched against each s_valid strobe by a negedge monitor.

module tb_pe_param;
    localparam int DW = 16, AW = 40, DEPTH = 4, CW = 8;

    logic          clk, rst_n;
    logic [DW-1:0] a_in, b_in;
    logic          a_we, b_we, a_full, b_full, start, stall;
    logic [CW-1:0] len;
    logic [5:0]    shamt;
    logic [DW-1:0] a_out, b_out, s_out;
    logic          ab_valid, start_next, s_valid, sat, ovf;

    typedef struct {
        logic [DW-1:0] val;
        logic          sat;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   obs_cyc[$];
    int   cyc;
    int   checks, errors;

    pe_param #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a_in       (a_in),
        .a_we       (a_we),
        .b_in       (b_in),
        .b_we       (b_we),
        .a_full     (a_full),
        .b_full     (b_full),
        .start      (start),
        .len        (len),
        .shamt      (shamt),
        .stall      (stall),
        .a_out      (a_out),
        .b_out      (b_out),
        .ab_valid   (ab_valid),
        .start_next (start_next),
        .s_out      (s_out),
        .s_valid    (s_valid),
        .sat        (sat),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Scoreboard monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && s_valid) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_result cyc=%0d s_out=%0d sat=%0b", cyc, $signed(s_out), sat);
            end else begin
                mon_e = exp_q.pop_front();
                if ({s_out, sat} !== {mon_e.val, mon_e.sat}) begin
                    errors = errors + 1;
                    $display("FAIL result cyc=%0d got s_out=%0d sat=%0b exp s_out=%0d sat=%0b",
                             cyc, $signed(s_out), sat, $signed(mon_e.val), mon_e.sat);
                end
            end
            obs_cyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int a, input int b, input logic wa, input logic wb);
        a_in = DW'(a);
        b_in = DW'(b);
        a_we = wa;
        b_we = wb;
    endtask

    task automatic expect_res(input int v, input logic s);
        exp_t e;
        e.val = DW'(v);
        e.sat = s;
        exp_q.push_back(e);
    endtask

    task automatic wait_results(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL result_timeout pending=%0d exp 0", exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int l, input int sh, output int s);
        tick();
        start = 1'b1;
        len   = CW'(l);
        shamt = 6'(sh);
        s     = cyc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        put(0, 0, 1'b0, 1'b0);
        start = 0; stall = 0; len = '0; shamt = '0;
        repeat (2) @(negedge clk);
        checks = checks + 1;
        if ({a_out, b_out, s_out, ab_valid, s_valid, sat, ovf, start_next, a_full, b_full} !== '0) begin
            errors = errors + 1;
            $display("FAIL reset_outputs got a_out=%0h b_out=%0h s_out=%0h flags=%b exp all 0",
                     a_out, b_out, s_out, {ab_valid, s_valid, sat, ovf, start_next, a_full, b_full});
        end
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_dot();
        int s;
        exp_q.delete(); obs_cyc.delete();
        expect_res(70, 1'b0);
        do_start(3, 0, s);
        tick(); start = 0; put(1, 5, 1, 1);
        @(negedge clk);
        checks = checks + 1;
        if (start_next !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL start_next got %0b exp 1", start_next);
        end
        tick(); put(2, 6, 1, 1);
        tick(); put(3, 7, 1, 1);
        @(negedge clk);
        checks = checks + 1;
        if ({ab_valid, a_out, b_out} !== {1'b1, DW'(1), DW'(5)}) begin
            errors = errors + 1;
            $display("FAIL forward got ab_valid=%0b a_out=%0d b_out=%0d exp 1 1 5", ab_valid, a_out, b_out);
        end
        tick(); put(4, 8, 1, 1);
        tick(); put(0, 0, 0, 0);
        wait_results(40);
        checks = checks + 1;
        if (obs_cyc.size() != 1 || obs_cyc[0] != s + 9) begin
            errors = errors + 1;
            $display("FAIL dot_latency got n=%0d cyc=%0d exp n=1 cyc=%0d",
                     obs_cyc.size(), (obs_cyc.size() > 0) ? obs_cyc[0] - s : -1, 9);
        end
    endtask

    task automatic test_saturation();
        int s;
        exp_q.delete(); obs_cyc.delete();
        expect_res(32767, 1'b1);
        expect_res(-32768, 1'b1);
        do_start(1, 0, s);
        tick(); start = 0; put(32767, 32767, 1, 1);
        tick(); put(32767, 32767, 1, 1);
        tick(); put(-32768, 32767, 1, 1);
        tick(); put(-32768, 32767, 1, 1);
        tick(); put(0, 0, 0, 0);
        wait_results(40);
    endtask

    task automatic test_rounding();
        int s;
        exp_q.delete(); obs_cyc.delete();
        expect_res(2, 1'b0);
        expect_res(-2, 1'b0);
        expect_res(2, 1'b0);
        do_start(0, 2, s);
        tick(); start = 0; put(3, 3, 1, 1);
        tick(); put(-3, 3, 1, 1);
        tick(); put(2, 3, 1, 1);
        tick(); put(0, 0, 0, 0);
        wait_results(40);
        for (int i = 0; i < 3; i++) begin
            checks = checks + 1;
            if (obs_cyc.size() != 3 || obs_cyc[i] != s + 6 + i) begin
                errors = errors + 1;
                $display("FAIL stream_cycle[%0d] got %0d exp %0d", i,
                         (obs_cyc.size() > i) ? obs_cyc[i] - s : -1, 6 + i);
            end
        end
    endtask

    task automatic test_overflow();
        int s;
        exp_q.delete(); obs_cyc.delete();
        do_start(0, 0, s);
        tick(); start = 0; put(100, 0, 1, 0);
        tick(); put(200, 0, 1, 0);
        tick(); put(300, 0, 1, 0);
        tick(); put(400, 0, 1, 0);
        @(negedge clk);
        checks = checks + 1;
        if (a_full !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL a_full_early got %0b exp 0", a_full);
        end
        tick(); put(500, 0, 1, 0);
        @(negedge clk);
        checks = checks + 1;
        if (a_full !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL a_full got %0b exp 1", a_full);
        end
        tick(); put(0, 0, 0, 0);
        @(negedge clk);
        checks = checks + 1;
        if (ovf !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL ovf_set got %0b exp 1", ovf);
        end
        for (int i = 1; i <= 4; i++) expect_res(100 * i, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(); put(0, 1, 0, 1);
        end
        tick(); put(0, 0, 0, 0);
        wait_results(40);
        checks = checks + 1;
        if ({ovf, a_full} !== 2'b10) begin
            errors = errors + 1;
            $display("FAIL ovf_hold got ovf=%0b a_full=%0b exp 1 0", ovf, a_full);
        end
        do_start(0, 0, s);
        tick(); start = 0;
        @(negedge clk);
        checks = checks + 1;
        if (ovf !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL ovf_clear got %0b exp 0", ovf);
        end
        repeat (6) tick();
    endtask

    task automatic test_stall();
        int s;
        exp_q.delete(); obs_cyc.delete();
        expect_res(80, 1'b0);
        expect_res(320, 1'b0);
        do_start(1, 0, s);
        tick(); start = 0; put(10, 2, 1, 1);
        tick(); put(20, 3, 1, 1);
        tick(); put(30, 4, 1, 1);
        tick(); put(40, 5, 1, 1); stall = 1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                tick(); put(0, 0, 0, 0);
            end
            @(negedge clk);
            checks = checks + 1;
            if (ab_valid !== 1'b0) begin
                errors = errors + 1;
                $display("FAIL ab_valid_in_stall[%0d] got %0b exp 0", i, ab_valid);
            end
        end
        tick(); stall = 0;
        @(negedge clk);
        checks = checks + 1;
        if ({ab_valid, a_out} !== {1'b1, DW'(20)}) begin
            errors = errors + 1;
            $display("FAIL ab_reissue got ab_valid=%0b a_out=%0d exp 1 20", ab_valid, a_out);
        end
        wait_results(40);
        checks = checks + 1;
        if (obs_cyc.size() != 2 || obs_cyc[0] != s + 10 || obs_cyc[1] != s + 12) begin
            errors = errors + 1;
            $display("FAIL stall_timing got n=%0d first=%0d second=%0d exp n=2 10 12", obs_cyc.size(),
                     (obs_cyc.size() > 0) ? obs_cyc[0] - s : -1, (obs_cyc.size() > 1) ? obs_cyc[1] - s : -1);
        end
    endtask

    task automatic test_mid_reset();
        int s;
        exp_q.delete(); obs_cyc.delete();
        do_start(3, 0, s);
        tick(); start = 0; put(1, 1, 1, 1);
        tick(); put(2, 2, 1, 1);
        tick(); put(3, 0, 1, 0);
        tick(); put(0, 0, 0, 0); rst_n = 0;
        @(negedge clk);
        checks = checks + 1;
        if ({a_out, b_out, s_out, ab_valid, s_valid, sat, ovf, start_next, a_full, b_full} !== '0) begin
            errors = errors + 1;
            $display("FAIL mid_reset_outputs got a_out=%0h b_out=%0h s_out=%0h flags=%b exp all 0",
                     a_out, b_out, s_out, {ab_valid, s_valid, sat, ovf, start_next, a_full, b_full});
        end
        tick(); tick(); rst_n = 1;
        expect_res(-14, 1'b0);
        tick(); put(7, -2, 1, 1);
        tick(); put(0, 0, 0, 0);
        wait_results(40);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        test_reset();
        test_dot();
        test_saturation();
        test_rounding();
        test_overflow();
        test_stall();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pe_param.md
# pe_param

Parametrised systolic-array processing element. Generalises the fixed 16-bit PE with configurable data width, accumulator width, and input FIFO depth. Adds a registered handshake toward neighbours, a stall input, a programmable rounding right-shift, a saturating output, and a sticky FIFO-overflow flag. It sits at each grid node: it consumes A from the west and B from the north, forwards them east and south, and emits one dot-product result per `len+1` operand pairs.

## Interface
- `DW`, 16: operand and result width (signed).
- `AW`, 40: accumulator width (signed); must be ≥ 2·DW.
- `DEPTH`, 4: entries per input FIFO (power of 2, ≥ 2).
- `CW`, 8: width of the element counter.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `a_in` in DW: A operand.
- `a_we` in 1: A write strobe.
- `b_in` in DW: B operand.
- `b_we` in 1: B write strobe.
- `a_full` out 1: A FIFO holds DEPTH entries.
- `b_full` out 1: B FIFO holds DEPTH entries.
- `start` in 1: begin a new dot product; latches `len` and `shamt`.
- `len` in CW: element count minus 1.
- `shamt` in 6: result right-shift amount, 0..AW-1.
- `stall` in 1: freeze pipeline and FIFO reads.
- `a_out` out DW: forwarded A.
- `b_out` out DW: forwarded B.
- `ab_valid` out 1: `a_out`/`b_out` updated this cycle; drives neighbour `a_we`/`b_we`.
- `start_next` out 1: `start` delayed by 1 cycle.
- `s_out` out DW: rounded, saturated result.
- `s_valid` out 1: one-cycle result strobe.
- `sat` out 1: `s_out` was clipped; valid only with `s_valid`.
- `ovf` out 1: sticky flag, set when a write hits a full FIFO.

## Operation
- Each FIFO is synchronous with registered `dout`.
  - A write when full is dropped and sets `ovf`. Full is evaluated before any same-cycle pop, so a write is dropped even if a pop happens in the same cycle.
  - A written word becomes poppable the cycle after the write.
- `fire` = A non-empty & B non-empty & ~`stall` & ~`start`. It is combinational. On `fire`, one entry pops from each FIFO.
- Pipeline; every stage holds its value while `stall`=1.
  - S1: on `fire`, operands are registered, `a_out`/`b_out` are loaded, and `ab_valid`=1.
  - S2: product = opA·opB, full 2·DW signed width, sign-extended to AW.
  - S3 (accumulate): if `cnt`≠0, `acc` ← `acc`+prod and `cnt` decrements. If `cnt`=0, this is the final element:
    - `sum` = `acc`+prod.
    - `s_out` ← sat(round(`sum`, `shamt_r`)), `s_valid`=1.
    - `acc` ← 0 and `cnt` ← `len_r`.
- Rounding: when `shamt_r`>0, add 2^(`shamt_r`−1), then arithmetic-shift right. `shamt_r`=0 passes the value unchanged.
- Saturation: clamp to [−2^(DW−1), 2^(DW−1)−1], with `sat`=1 when clamped.
- `acc` wraps modulo 2^AW; it is not checked.
- `start` has priority over everything else:
  - `cnt` ← `len`, `len_r` ← `len`, `shamt_r` ← `shamt`, `acc` ← 0, `ovf` ← 0.
  - S1/S2 valid bits are cleared, so in-flight pairs are discarded.
  - FIFO contents are kept.
  - `start_next` ← `start` regardless of `stall`.
- Back-to-back results need no idle cycle; `cnt` reloads on the final element.

## Timing
- Reset values:
  - All outputs 0, except `a_full`/`b_full`=0 (FIFOs empty).
  - `cnt`=0, so a single pair with no `start` yields a result.
- Latency from `fire` (cycle 0): `ab_valid` in cycle 1, product in cycle 2, accumulate/result edge at end of cycle 3, `s_valid` high in cycle 4.
- `stall` asserted for k cycles delays every downstream event by exactly k cycles. `s_valid` and `ab_valid` are forced low while `stall`=1 and re-issue once, not repeatedly.
- Throughput is 1 pair per cycle when both FIFOs are continuously non-empty.
- `rst_n` low mid-operation clears FIFOs, pipeline, `acc`, `cnt`, and flags immediately.

## Test plan
- Dot product: `start`, `len`=3, `shamt`=0; A=1,2,3,4, B=5,6,7,8 → single `s_valid` with `s_out`=70, `sat`=0, 4 cycles after the 4th `fire`.
- Saturation, `len`=1:
  - A=32767,32767 and B=32767,32767 → `s_out`=32767, `sat`=1.
  - A=−32768,−32768 and B=32767,32767 → `s_out`=−32768, `sat`=1.
- Rounding, `len`=0, `shamt`=2:
  - A=3, B=3 → `s_out`=2.
  - A=−3, B=3 → `s_out`=−2.
  - A=2, B=3 → `s_out`=2.
- Overflow: 5 A writes with B empty → `a_full`=1 after the 4th write, 5th write dropped, `ovf`=1. Then supply B=1×4 → `s_valid` results carry only the first 4 A values. Next `start` clears `ovf`.
- Stall and streaming: `len`=1, 4 pairs streamed, 3-cycle `stall` inserted after the 2nd `fire` → two results, the second delayed exactly 3 cycles, with values unaffected.
- Reset: drop `rst_n` between fires 2 and 3 → all outputs 0 and FIFOs empty. After release, a fresh `len`=0 pair A=7, B=−2 → `s_out`=−14.
